// File: rtl/receive_data.sv
// receive_data: parses SYNC_BYTE,TYPE,PAYLOAD[,CHECKSUM] byte frames into game-state / machine-target registers
// Optional feature: RX_CHECKSUM_EN adds a CHK byte (TYPE^PAYLOAD) after PAYLOAD.
// Ports:
//   uart_clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   GameStateData              last accepted game-state payload
//   MachineTargetData          last accepted machine-target payload
//   game_state_upd             pulse when GameStateData is written
//   machine_target_upd         pulse when MachineTargetData is written
//   frame_err, err_count       reject pulse and saturating reject count
//   recv_led, leds             toggle per accepted frame, last accepted payload
module receive_data #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] GameStateData,
  output logic [7:0] MachineTargetData,
  output logic       game_state_upd,
  output logic       machine_target_upd,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       recv_led,
  output logic [7:0] leds
);
`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, CHK} state_t;
  logic [7:0] pay_q;
`else
  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD} state_t;
`endif
  state_t      state_q;
  logic [7:0]  type_q;
  logic [15:0] cnt_q;
  logic        tmo, type_ok, done, rej;
  logic [7:0]  dval;
  always_comb begin
    // timeout fires on the cycle the counter would reach TIMEOUT_CYCLES; a byte in that cycle wins
    tmo     = !rx_valid && state_q != IDLE && cnt_q == TIMEOUT_CYCLES - 16'd1;
    type_ok = rx_data == 8'h01 || rx_data == 8'h02;
`ifdef RX_CHECKSUM_EN
    done    = rx_valid && state_q == CHK && rx_data == (type_q ^ pay_q);
    rej     = tmo || (rx_valid && ((state_q == TYPE && !type_ok) || (state_q == CHK && !done)));
    dval    = pay_q;
`else
    done    = rx_valid && state_q == PAYLOAD;
    rej     = tmo || (rx_valid && state_q == TYPE && !type_ok);
    dval    = rx_data;
`endif
  end
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      type_q             <= 8'h00;
`ifdef RX_CHECKSUM_EN
      pay_q              <= 8'h00;
`endif
      cnt_q              <= 16'h0000;
      GameStateData      <= 8'h00;
      MachineTargetData  <= 8'h00;
      game_state_upd     <= 1'b0;
      machine_target_upd <= 1'b0;
      frame_err          <= 1'b0;
      err_count          <= 8'h00;
      recv_led           <= 1'b0;
      leds               <= 8'h00;
    end else begin
      game_state_upd     <= 1'b0;
      machine_target_upd <= 1'b0;
      frame_err          <= rej;
      cnt_q              <= (rx_valid || state_q == IDLE) ? 16'h0000 : cnt_q + 16'd1;
      if (rx_valid && state_q == TYPE) type_q <= rx_data;
`ifdef RX_CHECKSUM_EN
      if (rx_valid && state_q == PAYLOAD) pay_q <= rx_data;
`endif
      if (rej && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (done) begin
        leds     <= dval;
        recv_led <= ~recv_led;
        if (type_q == 8'h01) begin
          GameStateData  <= dval;
          game_state_upd <= 1'b1;
        end else begin
          MachineTargetData  <= dval;
          machine_target_upd <= 1'b1;
        end
      end
      if (rej || done) state_q <= IDLE;
      else if (rx_valid)
`ifdef RX_CHECKSUM_EN
        state_q <= state_q == IDLE ? (rx_data == SYNC_BYTE ? TYPE : IDLE) : state_q == TYPE ? PAYLOAD : CHK;
`else
        state_q <= state_q == IDLE ? (rx_data == SYNC_BYTE ? TYPE : IDLE) : PAYLOAD;
`endif
    end
  end
endmodule

// File: tb/tb_receive_data.sv
// tb_receive_data: randomized scoreboard bench for receive_data against a byte-list frame model
module tb_receive_data;
  localparam int T = 20;
`ifdef RX_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif
  logic       uart_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] GameStateData, MachineTargetData, err_count, leds;
  logic       game_state_upd, machine_target_upd, frame_err, recv_led;
  receive_data #(.TIMEOUT_CYCLES(16'(T)), .SYNC_BYTE(8'hA5)) dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .GameStateData(GameStateData), .MachineTargetData(MachineTargetData),
    .game_state_upd(game_state_upd), .machine_target_upd(machine_target_upd),
    .frame_err(frame_err), .err_count(err_count), .recv_led(recv_led), .leds(leds)
  );
  always #5 uart_clk = ~uart_clk;
  typedef struct {
    logic [7:0] kind;
    logic [7:0] gs, mt, led, ec;
    logic       rl;
  } exp_t;
  exp_t       q[$];
  exp_t       e;
  int         total = 0, bad = 0;
  logic [7:0] m_gs = 8'h00, m_mt = 8'h00, m_led = 8'h00, m_ec = 8'h00;
  logic       m_rl = 1'b0;
  logic [7:0] fr[$];
  int         gap = 0;
  task automatic chk(string n, logic [7:0] a, logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h at %0t", n, a, x, $time);
    end
  endtask
  // kind: 1 game-state accept, 2 machine-target accept, 4 reject
  task automatic push_ev(logic [7:0] kind, logic [7:0] d);
    exp_t x;
    if (kind == 8'd4) m_ec = m_ec == 8'hFF ? m_ec : m_ec + 8'd1;
    else begin
      if (kind == 8'd1) m_gs = d; else m_mt = d;
      m_led = d;
      m_rl  = ~m_rl;
    end
    x.kind = kind; x.gs = m_gs; x.mt = m_mt; x.led = m_led; x.ec = m_ec; x.rl = m_rl;
    q.push_back(x);
  endtask
  task automatic model(logic v, logic [7:0] b);
    if (v) begin
      gap = 0;
      if (fr.size() > 0 || b == 8'hA5) fr.push_back(b);
      if (fr.size() == 2 && fr[1] != 8'h01 && fr[1] != 8'h02) begin
        push_ev(8'd4, 8'h00);
        fr.delete();
      end else if (fr.size() == FLEN) begin
        if (FLEN == 4 && fr[FLEN-1] != (fr[1] ^ fr[2])) push_ev(8'd4, 8'h00);
        else push_ev(fr[1] == 8'h01 ? 8'd1 : 8'd2, fr[2]);
        fr.delete();
      end
    end else if (fr.size() > 0) begin
      gap++;
      if (gap == T) begin
        push_ev(8'd4, 8'h00);
        fr.delete();
        gap = 0;
      end
    end
  endtask
  task automatic cyc(logic v, logic [7:0] b);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    model(v, b);
    @(posedge uart_clk);
    #1;
  endtask
  task automatic send(logic [7:0] b);
    cyc(1'b1, b);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    rx_valid = 1'b0;
  endtask
  task automatic frame(logic [7:0] t, logic [7:0] p);
    send(8'hA5); send(t); send(p);
`ifdef RX_CHECKSUM_EN
    send(t ^ p);
`endif
    rx_valid = 1'b0;
  endtask
  task automatic zero_chk(string n);
    chk({n, ".gs"}, GameStateData, 8'h00);
    chk({n, ".mt"}, MachineTargetData, 8'h00);
    chk({n, ".leds"}, leds, 8'h00);
    chk({n, ".ec"}, err_count, 8'h00);
    chk({n, ".pulses"}, {4'h0, game_state_upd, machine_target_upd, frame_err, recv_led}, 8'h00);
  endtask
  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    zero_chk("reset");
    fr.delete(); gap = 0; q.delete();
    m_gs = 8'h00; m_mt = 8'h00; m_led = 8'h00; m_ec = 8'h00; m_rl = 1'b0;
    repeat (2) @(posedge uart_clk);
    #1;
    zero_chk("reset_hold");
    rst_n = 1'b1;
  endtask
  always @(negedge uart_clk) begin
    if (rst_n && (game_state_upd || machine_target_upd || frame_err)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event got=%b%b%b want=none at %0t", frame_err, machine_target_upd, game_state_upd, $time);
      end else begin
        e = q.pop_front();
        chk("event_kind", {5'b0, frame_err, machine_target_upd, game_state_upd}, e.kind);
        chk("GameStateData", GameStateData, e.gs);
        chk("MachineTargetData", MachineTargetData, e.mt);
        chk("leds", leds, e.led);
        chk("err_count", err_count, e.ec);
        chk("recv_led", {7'b0, recv_led}, {7'b0, e.rl});
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] pick[4];
    int r;
    repeat (2) @(posedge uart_clk);
    #1;
    zero_chk("por");
    rst_n = 1'b1;
    frame(8'h01, 8'h3C); idle(2);
    frame(8'h02, 8'h7F); frame(8'h01, 8'h05); idle(2);
    send(8'hA5); send(8'h09); send(8'h11); idle(2);
    send(8'hA5); send(8'h01); idle(T); frame(8'h01, 8'h22); idle(2);
    send(8'hA5); send(8'h01); idle(T - 1); send(8'h33);
`ifdef RX_CHECKSUM_EN
    idle(T - 1); send(8'h01 ^ 8'h33);
`endif
    idle(2);
    frame(8'h02, 8'hA5); idle(2);
`ifdef RX_CHECKSUM_EN
    send(8'hA5); send(8'h02); send(8'h0F); send(8'h0D); idle(1);
    send(8'hA5); send(8'h02); send(8'h0F); send(8'h00); idle(2);
`endif
    send(8'hA5); send(8'h01); idle(1);
    do_reset();
    frame(8'h01, 8'h44); idle(3);
    chk("err_after_reset", err_count, 8'h00);
    pick[0] = 8'hA5; pick[1] = 8'h01; pick[2] = 8'h02;
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 19));
      pick[3] = 8'($urandom);
      if (r < 6) idle(1);
      else if (r == 19) idle(T - 2 + int'($urandom_range(0, 3)));
      else send(pick[$urandom_range(0, 3)]);
    end
    idle(T + 2);
    for (int i = 0; i < 260; i++) begin
      send(8'hA5); send(8'h09);
    end
    idle(3);
    chk("err_saturated", err_count, 8'hFF);
    idle(4);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, giving the maximum uart_clk cycles allowed between bytes of one frame.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 The block SHALL have port uart_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits: byte from the UART receiver, valid only while rx_valid=1.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe per received byte.
REQ-007 The block SHALL have port GameStateData, output reg, 8 bits: last accepted game-state payload.
REQ-008 The block SHALL have port MachineTargetData, output reg, 8 bits: last accepted machine-target payload.
REQ-009 The block SHALL have port game_state_upd, output reg, 1 bit: one-cycle pulse when GameStateData is written.
REQ-010 The block SHALL have port machine_target_upd, output reg, 1 bit: one-cycle pulse when MachineTargetData is written.
REQ-011 The block SHALL have port frame_err, output reg, 1 bit: one-cycle pulse per rejected frame.
REQ-012 The block SHALL have port err_count, output reg, 8 bits: count of rejected frames, saturating at 8'hFF.
REQ-013 The block SHALL have port recv_led, output reg, 1 bit: toggles on each accepted frame.
REQ-014 The block SHALL have port leds, output reg, 8 bits: payload of the last accepted frame.

Function
REQ-015 The FSM SHALL use states IDLE, TYPE, PAYLOAD, and CHK (CHK only with RX_CHECKSUM_EN); bytes are consumed only in cycles with rx_valid=1.
REQ-016 In IDLE, a byte equal to SYNC_BYTE SHALL move to TYPE; any other byte SHALL be ignored with no error.
REQ-017 In TYPE, byte 8'h01 (game state) or 8'h02 (machine target) SHALL be latched and move to PAYLOAD; any other value SHALL reject the frame and return to IDLE.
REQ-018 In PAYLOAD, the byte SHALL be latched; without the checksum, the frame completes and the FSM returns to IDLE.
REQ-019 On frame completion, the selected data register, leds, and recv_led SHALL update, and the matching *_upd SHALL be 1, in the cycle after the final byte's rx_valid cycle; *_upd SHALL be high for exactly one cycle.
REQ-020 A completed frame SHALL update only its own register; the other data register SHALL hold its value.
REQ-021 Rejection SHALL pulse frame_err for one cycle in the cycle after the causing event, increment err_count unless it is 8'hFF, and write no data register.
REQ-022 An inter-byte counter SHALL clear on every rx_valid and, outside IDLE, count uart_clk cycles.
REQ-023 Reaching TIMEOUT_CYCLES without rx_valid SHALL reject the frame and return to IDLE.
REQ-024 If rx_valid coincides with the timeout cycle, the byte SHALL be processed and no timeout SHALL occur.
REQ-025 A SYNC_BYTE value received in PAYLOAD or CHK SHALL be treated as data, with no resynchronisation.
REQ-026 Back-to-back frames with no idle cycles SHALL all be accepted.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE, and GameStateData, MachineTargetData, leds, err_count, and the counter SHALL be 0.
REQ-028 While rst_n=0, game_state_upd, machine_target_upd, frame_err, and recv_led SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no error count.
REQ-030 Bytes SHALL be accepted from the first rising edge after rst_n deasserts.

Configuration
REQ-031 With macro RX_CHECKSUM_EN defined, PAYLOAD SHALL move to CHK.
REQ-032 In CHK, a byte equal to TYPE^PAYLOAD SHALL complete the frame; any other value SHALL reject it.
REQ-033 With RX_CHECKSUM_EN undefined, CHK SHALL not exist, and frames SHALL be 3 bytes.

Verification
REQ-034 Bench scenario: A5,01,3C -> GameStateData=3C, game_state_upd one pulse, recv_led toggles, leds=3C.
REQ-035 Bench scenario: A5,02,7F then A5,01,05 back-to-back -> MachineTargetData=7F, then GameStateData=05, with MachineTargetData unchanged.
REQ-036 Bench scenario: A5,09,11 -> frame_err pulse, err_count=1, 11 ignored in IDLE, and data unchanged.
REQ-037 Bench scenario: A5,01, then TIMEOUT_CYCLES idle cycles -> frame_err, then a subsequent A5,01,22 is accepted.
REQ-038 Bench scenario (RX_CHECKSUM_EN): A5,02,0F,0D -> MachineTargetData=0F; A5,02,0F,00 -> frame_err and no update.
REQ-039 Bench scenario: rst_n low after A5,01 -> all outputs 0; after release, A5,01,44 gives GameStateData=44 and err_count=0.
